irq_controller: RTL

Interrupt controller that receives the one-cycle interrupt pulses produced by the periodic timer and other peripherals, and presents them to the single-cycle CPU. It latches each pulse into a sticky pending bit, applies a software-writable mask, selects the highest-priority request, and runs a request/acknowledge/end-of-interrupt handshake with the CPU control unit. It sits between the peripheral pulse lines and the CPU's interrupt input and vector mux.

---
 rtl/irq_controller.sv | 131 +++++++++++++
 1 files changed

// File: rtl/irq_controller.sv
// ---------------------------------------------------------------------------
// irq_controller
//
// Collects one-cycle interrupt pulses from the peripherals into sticky pending
// bits. It gates them with a software-writable mask and picks the
// highest-index enabled source. It then runs a request / acknowledge /
// end-of-interrupt handshake with the CPU control unit. Nesting is not
// supported: while a source is in service, new pulses only accumulate in
// pending.
//
// Parameters:
//   WIDTH      number of interrupt sources (WIDTH-1 = timer, highest priority)
//   MASK_INIT  mask value loaded on reset (1 = enabled)
//   VW         vector width, derived from WIDTH
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   src         per-source one-cycle interrupt pulses
//   mask_we     mask write enable
//   mask_in     new mask value
//   ack         CPU accepts the current request
//   eoi         CPU finished the interrupt service routine
//   irq         registered interrupt request to the CPU
//   vector      registered index of the requested / in-service source
//   pending     sticky pending bits
//   mask        current mask
//   overrun     sticky flag: a pulse arrived while that source was pending
//   in_service  high while a source is being serviced
// ---------------------------------------------------------------------------
module irq_controller #(
  parameter  int               WIDTH     = 8,
  parameter  logic [WIDTH-1:0] MASK_INIT = 8'hFF,
  localparam int               VW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] src,
  input  logic             mask_we,
  input  logic [WIDTH-1:0] mask_in,
  input  logic             ack,
  input  logic             eoi,
  output logic             irq,
  output logic [VW-1:0]    vector,
  output logic [WIDTH-1:0] pending,
  output logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] overrun,
  output logic             in_service
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] req;
  logic [VW-1:0]    sel;
  logic             ack_fire;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] mask_next;

  // Priority pick and per-cycle clear vector. The ascending scan lets the
  // highest enabled index overwrite lower ones. The clear only happens on an
  // accepted ack, and it targets the latched vector rather than the current
  // pick.
  always_comb begin
    req = pending & mask;
    sel = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (req[i]) sel = VW'(i);
    end
    ack_fire  = (state == REQ) && ack;
    clr       = ack_fire ? ({{(WIDTH-1){1'b0}}, 1'b1} << vector) : '0;
    mask_next = mask_we ? mask_in : mask;
  end

  // Pending/overrun bookkeeping and the handshake FSM. A new pulse always
  // wins over a clear, so a pulse coinciding with its own ack re-arms the
  // source. An overrun is only flagged when the old pending bit survives
  // this cycle. The drop check in REQ uses the mask value being written
  // this cycle, so disabling the source and dropping the request happen on
  // the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pending    <= '0;
      overrun    <= '0;
      mask       <= MASK_INIT;
      irq        <= 1'b0;
      vector     <= '0;
      in_service <= 1'b0;
    end else begin
      pending <= (pending & ~clr) | src;
      overrun <= (overrun & ~clr) | (src & pending & ~clr);
      mask    <= mask_next;
      case (state)
        IDLE: begin
          if (|req) begin
            state  <= REQ;
            irq    <= 1'b1;
            vector <= sel;
          end
        end
        REQ: begin
          if (ack) begin
            state      <= SERVICE;
            irq        <= 1'b0;
            in_service <= 1'b1;
          end else if (!mask_next[vector]) begin
            state <= IDLE;
            irq   <= 1'b0;
          end
        end
        SERVICE: begin
          if (eoi) begin
            state      <= IDLE;
            in_service <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          irq        <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

endmodule
